// File: rtl/rom_rr_arbiter.sv
// rtl/rom_rr_arbiter.sv - round-robin arbiter sharing one synchronous ROM read port
module rom_rr_arbiter #(
  parameter int NREQ   = 4,
  parameter int AW     = 4,
  parameter int DW     = 16,
  parameter int RD_LAT = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*AW-1:0] req_addr,
  output logic [NREQ-1:0]    req_ready,
  output logic [NREQ-1:0]    rsp_valid,
  output logic [DW-1:0]      rsp_data,
  output logic               rom_en,
  output logic [AW-1:0]      rom_addr,
  input  logic [DW-1:0]      rom_dout
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic [IDW-1:0] sel;
  logic [IDW-1:0] gnt_id;
  logic           found;
  logic [AW-1:0]  addr_arr [NREQ];

  logic [RD_LAT:0] tag_v;
  logic [IDW-1:0]  tag_id [RD_LAT+1];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_addr
    assign addr_arr[gi] = req_addr[gi*AW +: AW];
  end

  // Search from the pointer, wrapping modulo NREQ; first valid requester wins.
  always_comb begin
    req_ready = '0;
    gnt_id    = '0;
    sel       = '0;
    found     = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      if ((int'(ptr) + k) >= NREQ) begin
        sel = IDW'(int'(ptr) + k - NREQ);
      end else begin
        sel = IDW'(int'(ptr) + k);
      end
      if (!found && req_valid[sel]) begin
        req_ready[sel] = 1'b1;
        gnt_id         = sel;
        found          = 1'b1;
      end
    end
    if (rst) begin
      req_ready = '0;
      found     = 1'b0;
    end
  end

  assign ptr_nxt = (int'(gnt_id) == NREQ - 1) ? '0 : gnt_id + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      rom_en   <= 1'b0;
      rom_addr <= '0;
      ptr      <= '0;
      tag_v    <= '0;
      for (int s = 0; s <= RD_LAT; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      rom_en <= found;
      if (found) begin
        rom_addr <= addr_arr[gnt_id];
        ptr      <= ptr_nxt;
      end
      // Stage 0 lines up with rom_en; the last stage lines up with valid rom_dout.
      tag_v     <= {tag_v[RD_LAT-1:0], found};
      tag_id[0] <= gnt_id;
      for (int s = 1; s <= RD_LAT; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (tag_v[RD_LAT]) begin
      rsp_valid[tag_id[RD_LAT]] = 1'b1;
    end
  end

  assign rsp_data = rom_dout;

endmodule

// File: tb/tb_rom_rr_arbiter.sv
// tb/tb_rom_rr_arbiter.sv - directed table-driven bench for rom_rr_arbiter
module tb_rom_rr_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req_valid;
  logic [15:0] req_addr;
  logic [3:0]  req_ready;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_data;
  logic        rom_en;
  logic [3:0]  rom_addr;
  logic [15:0] rom_dout;

  logic [3:0]  req_valid2;
  logic [15:0] req_addr2;
  logic [3:0]  req_ready2;
  logic [3:0]  rsp_valid2;
  logic [15:0] rsp_data2;
  logic        rom_en2;
  logic [3:0]  rom_addr2;
  logic [15:0] rom_dout2;
  logic [15:0] lat_r1, lat_r2;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] addr;
    logic [3:0]  ready;
    logic        en;
    logic [3:0]  eaddr;
    logic [3:0]  rsp;
    logic [3:0]  raddr;
  } vec_t;

  vec_t vecs[$];

  rom_rr_arbiter #(.NREQ(4), .AW(4), .DW(16), .RD_LAT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .rom_en(rom_en), .rom_addr(rom_addr), .rom_dout(rom_dout)
  );

  rom_rr_arbiter #(.NREQ(4), .AW(4), .DW(16), .RD_LAT(3)) dut3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid2), .req_addr(req_addr2), .req_ready(req_ready2),
    .rsp_valid(rsp_valid2), .rsp_data(rsp_data2),
    .rom_en(rom_en2), .rom_addr(rom_addr2), .rom_dout(rom_dout2)
  );

  function automatic logic [15:0] rom_val(input logic [3:0] a);
    return ({12'h000, a} * 16'h0F1D) ^ 16'h5A3C;
  endfunction

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    rom_dout  = '0;
    rom_dout2 = '0;
    lat_r1    = '0;
    lat_r2    = '0;
  end

  always @(posedge clk) begin
    if (rom_en) rom_dout <= rom_val(rom_addr);
  end

  always @(posedge clk) begin
    if (rom_en2) lat_r1 <= rom_val(rom_addr2);
    lat_r2    <= lat_r1;
    rom_dout2 <= lat_r2;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] a0, input logic [3:0] a1,
                     input logic [3:0] a2, input logic [3:0] a3, input logic [3:0] rdy,
                     input logic en, input logic [3:0] ea, input logic [3:0] rsp,
                     input logic [3:0] ra);
    vec_t t;
    t.valid = v;
    t.addr  = {a3, a2, a1, a0};
    t.ready = rdy;
    t.en    = en;
    t.eaddr = ea;
    t.rsp   = rsp;
    t.raddr = ra;
    vecs.push_back(t);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    // 4-way contention from pointer 0
    add(4'hF, 3, 7, 11, 15, 4'h1, 0, 0,  4'h0, 0);
    add(4'hF, 3, 7, 11, 15, 4'h2, 1, 3,  4'h0, 0);
    add(4'hF, 3, 7, 11, 15, 4'h4, 1, 7,  4'h1, 3);
    add(4'hF, 3, 7, 11, 15, 4'h8, 1, 11, 4'h2, 7);
    add(4'hF, 3, 7, 11, 15, 4'h1, 1, 15, 4'h4, 11);
    add(4'hF, 3, 7, 11, 15, 4'h2, 1, 3,  4'h8, 15);
    add(4'hF, 3, 7, 11, 15, 4'h4, 1, 7,  4'h1, 3);
    add(4'hF, 3, 7, 11, 15, 4'h8, 1, 11, 4'h2, 7);
    // requester 0 streams addresses 0..15
    for (int k = 0; k < 16; k++) begin
      add(4'h1, 4'(k), 0, 0, 0, 4'h1, 1,
          (k == 0) ? 4'd15 : 4'(k - 1),
          (k == 0) ? 4'h4 : (k == 1) ? 4'h8 : 4'h1,
          (k == 0) ? 4'd11 : (k == 1) ? 4'd15 : 4'(k - 2));
    end
    add(4'h0, 0, 0, 0, 0, 4'h0, 1, 15, 4'h1, 14);
    add(4'h0, 0, 0, 0, 0, 4'h0, 0, 0,  4'h1, 15);
    // requester 2 granted last, then 1 and 3 contend
    add(4'h4, 0, 0, 1, 0, 4'h4, 0, 0, 4'h0, 0);
    add(4'hA, 0, 2, 0, 4, 4'h8, 1, 1, 4'h0, 0);
    add(4'h2, 0, 2, 0, 0, 4'h2, 1, 4, 4'h4, 1);
    add(4'h0, 0, 0, 0, 0, 4'h0, 1, 2, 4'h8, 4);
    add(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h2, 2);
    add(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0);
    // sparse single request
    add(4'h4, 0, 0, 5, 0, 4'h4, 0, 0, 4'h0, 0);
    add(4'h0, 0, 0, 0, 0, 4'h0, 1, 5, 4'h0, 0);
    add(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h4, 5);
    add(4'h0, 0, 0, 0, 0, 4'h0, 0, 0, 4'h0, 0);

    rst        = 1'b1;
    req_valid  = '0;
    req_addr   = '0;
    req_valid2 = '0;
    req_addr2  = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    req_valid  = 4'hF;
    req_valid2 = 4'hF;
    #1;
    check("ready_in_reset", req_ready, 4'h0);
    check("ready2_in_reset", req_ready2, 4'h0);
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = '0;
    req_valid2 = '0;
    #1;
    check("reset_rom_en", rom_en, 1'b0);
    check("reset_rom_addr", rom_addr, 4'h0);
    check("reset_rsp_valid", rsp_valid, 4'h0);
    check("reset_rsp_valid2", rsp_valid2, 4'h0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      req_valid = vecs[i].valid;
      req_addr  = vecs[i].addr;
      #1;
      check($sformatf("v%0d ready", i), req_ready, vecs[i].ready);
      check($sformatf("v%0d rom_en", i), rom_en, vecs[i].en);
      if (vecs[i].en) check($sformatf("v%0d rom_addr", i), rom_addr, vecs[i].eaddr);
      check($sformatf("v%0d rsp_valid", i), rsp_valid, vecs[i].rsp);
      if (vecs[i].rsp != 4'h0)
        check($sformatf("v%0d rsp_data", i), rsp_data, rom_val(vecs[i].raddr));
    end

    // reset while reads are in flight; pointer currently at 3
    @(negedge clk);
    req_valid = 4'hF;
    req_addr  = {4'd15, 4'd11, 4'd7, 4'd3};
    #1;
    check("rst_seq ready0", req_ready, 4'h8);
    @(negedge clk);
    #1;
    check("rst_seq ready1", req_ready, 4'h1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_seq ready_rst", req_ready, 4'h0);
    check("rst_seq rsp_pre", rsp_valid, 4'h8);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_seq rsp_after0", rsp_valid, 4'h0);
    check("rst_seq rom_en_after0", rom_en, 1'b0);
    check("rst_seq ready_ptr0", req_ready, 4'h1);
    @(negedge clk);
    #1;
    check("rst_seq rsp_after1", rsp_valid, 4'h0);
    check("rst_seq rom_en_after1", rom_en, 1'b1);
    check("rst_seq rom_addr_after1", rom_addr, 4'd3);
    check("rst_seq ready_next", req_ready, 4'h2);
    @(negedge clk);
    req_valid = 4'h0;
    #1;
    check("rst_seq rsp_new0", rsp_valid, 4'h1);
    check("rst_seq data_new0", rsp_data, rom_val(4'd3));
    @(negedge clk);
    #1;
    check("rst_seq rsp_new1", rsp_valid, 4'h2);
    check("rst_seq data_new1", rsp_data, rom_val(4'd7));
    @(negedge clk);
    #1;
    check("rst_seq rsp_idle", rsp_valid, 4'h0);

    // RD_LAT=3 instance: requester 1 reads address 9
    @(negedge clk);
    req_valid2 = 4'h2;
    req_addr2  = 16'h0090;
    #1;
    check("lat3 ready", req_ready2, 4'h2);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      req_valid2 = 4'h0;
      #1;
      check($sformatf("lat3 rom_en k%0d", k), rom_en2, (k == 1) ? 1'b1 : 1'b0);
      if (k == 1) check("lat3 rom_addr", rom_addr2, 4'd9);
      check($sformatf("lat3 rsp_valid k%0d", k), rsp_valid2, (k == 4) ? 4'h2 : 4'h0);
      if (k == 4) check("lat3 rsp_data", rsp_data2, rom_val(4'd9));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
